// File: rtl/uart_pkg.sv
// Shared state encoding and line levels for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // 50 MHz system clock at 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period divider: bit_tick pulses in the last cycle of each CLKS_PER_BIT period.
// restart realigns the period to the cycle after it; no backpressure.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A restart on the terminal count must not also advance the frame FSM.
  assign bit_tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, parity with UART_TX_PARITY_EN, 1-2 stop).
// Start bit drives from the accept edge; tx_ready stays low for the whole frame plus its last stop bit.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                 parity_odd
`endif
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $error("uart_tx_param: illegal CLKS_PER_BIT, DATA_BITS or STOP_BITS");
    end
  endgenerate

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IW-1:0]        bit_idx;
  logic                 handshake;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign handshake = tx_valid && tx_ready && (state == IDLE);

  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (handshake),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= IDLE_LEVEL;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_ready  <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (handshake) begin
            state     <= START;
            tx        <= START_LEVEL;
            shift_reg <= tx_data;
            bit_idx   <= '0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^tx_data) ^ parity_odd;
`endif
          end else begin
            // Also raises tx_ready on the first edge after reset.
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx    <= shift_reg[0];
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= STOP_LEVEL;
`endif
            end else begin
              bit_idx   <= bit_idx + IW'(1);
              shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
              tx        <= shift_reg[1];
            end
          end
        end

        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx    <= STOP_LEVEL;
          end
        end

        STOP: begin
          if (bit_tick) begin
            // bit_idx is reused to count stop-bit periods.
            if (bit_idx == LAST_STOP) begin
              state    <= IDLE;
              tx       <= IDLE_LEVEL;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              bit_idx  <= '0;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench: two transmitters (8N1 and 5-bit/2-stop) at 4 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_a;
  logic [4:0] data_b;
  logic [1:0] valid_w, rdy_w, tx_w, busy_w, done_w, odd_w;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .reset(reset), .tx_data(data_a), .tx_valid(valid_w[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
`ifdef UART_TX_PARITY_EN
    , .parity_odd(odd_w[0])
`endif
  );

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset), .tx_data(data_b), .tx_valid(valid_w[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
`ifdef UART_TX_PARITY_EN
    , .parity_odd(odd_w[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line image of one frame, first bit on the wire in bit 0.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int db,
                                             input int sb, input logic odd);
    logic [15:0] f;
    int idx;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) f[1+i] = d[i];
    idx = 1 + db;
    if (P == 1) begin
      f[idx] = odd;
      for (int i = 0; i < db; i++) f[idx] = f[idx] ^ d[i];
      idx++;
    end
    for (int s = 0; s < sb; s++) f[idx+s] = 1'b1;
    return f;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int DB = (g == 0) ? 8 : 5;
    localparam int SB = (g == 0) ? 1 : 2;
    localparam int NB = 1 + DB + P + SB;
    localparam int FL = NB * CPB;

    logic [15:0] exp_q[$];
    logic        samp[0:63];
    int fc = -1;
    int idle_run = 0;
    int rdy_run = 0;
    int last_gap = 0;
    int last_rdy = 0;
    int frames = 0;

    always @(posedge clk) begin
      if (!reset && valid_w[g] && rdy_w[g])
        exp_q.push_back(frame_bits((g == 0) ? {1'b0, data_a} : {4'b0, data_b}, DB, SB, odd_w[g]));
    end

    always @(negedge clk) begin
      logic [15:0] obs;
      logic [15:0] expf;
      logic        stable;
      if (reset) begin
        fc = -1;
        exp_q.delete();
        idle_run = 0;
        rdy_run = 0;
      end else if (fc < 0) begin
        if (done_w[g]) check($sformatf("m%0d_spurious_done", g), 32'(done_w[g]), 0);
        if (busy_w[g]) begin
          last_gap = idle_run;
          last_rdy = rdy_run;
          idle_run = 0;
          rdy_run = 0;
          samp[0] = tx_w[g];
          fc = 1;
        end else begin
          idle_run++;
          if (rdy_w[g]) rdy_run++;
        end
      end else if (done_w[g]) begin
        check($sformatf("m%0d_frame_len", g), 32'(fc), 32'(FL));
        check($sformatf("m%0d_done_busy", g), 32'(busy_w[g]), 0);
        check($sformatf("m%0d_done_rdy", g), 32'(rdy_w[g]), 1);
        obs = '0;
        stable = 1'b1;
        for (int k = 0; k < NB; k++) begin
          obs[k] = samp[k*CPB];
          for (int c = 1; c < CPB; c++)
            if (samp[k*CPB+c] !== samp[k*CPB]) stable = 1'b0;
        end
        check($sformatf("m%0d_bit_stable", g), 32'(stable), 1);
        check($sformatf("m%0d_sb_pop", g), 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          expf = exp_q.pop_front();
          check($sformatf("m%0d_frame_bits", g), 32'(obs), 32'(expf));
        end
        frames++;
        fc = -1;
        idle_run = 1;
        rdy_run = rdy_w[g] ? 1 : 0;
      end else begin
        if (rdy_w[g]) check($sformatf("m%0d_rdy_in_frame", g), 32'(rdy_w[g]), 0);
        if (!busy_w[g]) begin
          check($sformatf("m%0d_busy_drop", g), 32'(busy_w[g]), 1);
          fc = -1;
        end else if (fc >= 64) begin
          check($sformatf("m%0d_frame_overrun", g), 32'(fc), 32'(FL));
          fc = -1;
        end else begin
          samp[fc] = tx_w[g];
          fc++;
        end
      end
    end
  end

  task automatic send(input int g, input logic [8:0] d, input logic odd, input bit keep);
    int n = 0;
    @(negedge clk);
    if (g == 0) data_a = d[7:0];
    else data_b = d[4:0];
    odd_w[g] = odd;
    valid_w[g] = 1'b1;
    while (!rdy_w[g] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("send_rdy_timeout", 32'(n < 500), 1);
    @(negedge clk);
    valid_w[g] = keep;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while ((busy_w[g] || !rdy_w[g]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("idle_timeout", 32'(n < 500), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr;
    reset = 1'b1;
    valid_w = '0;
    odd_w = '0;
    data_a = '0;
    data_b = '0;
    #1;
    check("rst_tx", 32'(tx_w), 32'h3);
    check("rst_busy", 32'(busy_w), 0);
    check("rst_done", 32'(done_w), 0);
    check("rst_rdy", 32'(rdy_w), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(rdy_w), 32'h3);

    // Basic frames on both configurations.
    send(0, 9'h0A5, 1'b0, 1'b0);
    send(1, 9'h013, 1'b0, 1'b0);
    wait_idle(0);
    wait_idle(1);
    send(0, 9'h0A5, 1'b1, 1'b0);
    wait_idle(0);

    // Back-to-back with tx_valid held high.
    send(0, 9'h000, 1'b0, 1'b1);
    send(0, 9'h0FF, 1'b0, 1'b0);
    wait_idle(0);
    check("b2b_gap", 32'(g_mon[0].last_gap), 1);
    check("b2b_rdy_cycles", 32'(g_mon[0].last_rdy), 1);

    // Random words, both instances overlapping in time.
    for (int i = 0; i < 6; i++) begin
      send(0, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      send(1, 9'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
      wait_idle(0);
      wait_idle(1);
    end

    // Input churn mid-frame must not disturb the word or cause a handshake.
    fr = g_mon[0].frames;
    send(0, 9'h03C, 1'b0, 1'b0);
    repeat (30) begin
      @(negedge clk);
      data_a = 8'($urandom);
      valid_w[0] = 1'($urandom_range(0, 1));
    end
    valid_w[0] = 1'b0;
    wait_idle(0);
    check("churn_frames", 32'(g_mon[0].frames - fr), 1);

    // Reset during data bit 3 of 0xA5 (a 0 on the line).
    fr = g_mon[0].frames;
    send(0, 9'h0A5, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    check("pre_rst_tx", 32'(tx_w[0]), 0);
    reset = 1'b1;
    #1;
    check("midrst_tx", 32'(tx_w[0]), 1);
    check("midrst_busy", 32'(busy_w[0]), 0);
    check("midrst_done", 32'(done_w[0]), 0);
    @(negedge clk);
    check("midrst_rdy", 32'(rdy_w[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_midrst", 32'(rdy_w[0]), 1);
    check("midrst_no_frame", 32'(g_mon[0].frames - fr), 0);
    send(0, 9'h05A, 1'b1, 1'b0);
    wait_idle(0);
    check("post_rst_frames", 32'(g_mon[0].frames - fr), 1);

    check("q0_drained", 32'(g_mon[0].exp_q.size()), 0);
    check("q1_drained", 32'(g_mon[1].exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
